// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - shared register map and DUTY constants for the LED PIO port
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_RESET = 8'hFF;

endpackage

// File: rtl/led_pio_prescaler.sv
// rtl/led_pio_prescaler.sv - blink half-period counter producing the shared blink phase
module led_pio_prescaler
    import led_pio_pkg::*;
#(
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic               phase_o
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // Restart outranks terminal count, and also covers PRESCALE dropping below cnt.
    always_comb begin
        cnt_d   = cnt_q + PRESC_W'(1);
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == prescale_i) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// rtl/led_pio_blink.sv - Avalon-MM LED/GPIO output port with set/clear aliases, blink and optional PWM (LED_PIO_PWM_EN)
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter int                PRESC_W     = 24,
    parameter logic [WIDTH-1:0]  DATA_RESET  = '0,
    parameter int unsigned       PRESC_RESET = 12499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   blink_en_q, blink_en_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               phase;
    logic               pwm_gate;
    logic               wr;
    logic [WIDTH-1:0]   wdata;
    logic               unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

`ifdef LED_PIO_PWM_EN
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] pwm_cnt_q;

    always_comb begin
        duty_d = duty_q;
        if (wr && address == ADDR_DUTY)
            duty_d = writedata[DUTY_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q    <= DUTY_RESET;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
        end
    end

    assign pwm_gate = (duty_q == '1) | (pwm_cnt_q < duty_q);
`else
    assign pwm_gate = 1'b1;
`endif

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        prescale_d = prescale_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d     = wdata;
                ADDR_BLINK_EN: blink_en_d = wdata;
                ADDR_PRESCALE: prescale_d = writedata[PRESC_W-1:0];
                ADDR_OUTSET:   data_d     = data_q | wdata;
                ADDR_OUTCLEAR: data_d     = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    led_pio_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .restart_i  (wr && address == ADDR_PRESCALE),
        .prescale_i (prescale_q),
        .phase_o    (phase)
    );

    assign out_d = data_q & (~blink_en_q | {WIDTH{phase}}) & {WIDTH{pwm_gate}};

    // PWM gate is 1 at reset (DUTY = 255), so the output simply presets to DATA_RESET.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= DATA_RESET;
            blink_en_q <= '0;
            prescale_q <= PRESC_W'(PRESC_RESET);
            out_q      <= DATA_RESET;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            prescale_q <= prescale_d;
            out_q      <= out_d;
        end
    end

    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PRESCALE: readdata = 32'(prescale_q);
`ifdef LED_PIO_PWM_EN
            ADDR_DUTY:     readdata = 32'(duty_q);
`endif
            ADDR_STATUS:   readdata = {31'b0, phase};
            default:       ;
        endcase
    end

endmodule

// File: tb/tb_led_pio_blink.sv
// tb/tb_led_pio_blink.sv - self-checking bench for led_pio_blink
module tb_led_pio_blink;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    led_pio_blink dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    int          highs;

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        vecs[0]  = '{1'b1, 3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00A5, 32'hA5};
        vecs[1]  = '{1'b1, 3'd4, 32'h0000_000A, 3'd0, 32'h0000_00AF, 32'hAF};
        vecs[2]  = '{1'b1, 3'd5, 32'h0000_0081, 3'd0, 32'h0000_002E, 32'h2E};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         3'd4, 32'h0,         32'h2E};
        vecs[4]  = '{1'b0, 3'd0, 32'h0,         3'd5, 32'h0,         32'h2E};
        vecs[5]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0,         32'h2E};
        vecs[6]  = '{1'b1, 3'd6, 32'h0,         3'd6, 32'h1,         32'h2E};
`ifdef LED_PIO_PWM_EN
        vecs[7]  = '{1'b1, 3'd3, 32'h0000_00FF, 3'd3, 32'h0000_00FF, 32'h2E};
`else
        vecs[7]  = '{1'b1, 3'd3, 32'h0000_00FF, 3'd3, 32'h0,         32'h2E};
`endif
        vecs[8]  = '{1'b1, 3'd1, 32'h0000_000F, 3'd1, 32'h0000_000F, 32'h2E};
        vecs[9]  = '{1'b1, 3'd1, 32'h0,         3'd1, 32'h0,         32'h2E};
        vecs[10] = '{1'b1, 3'd0, 32'h1234_56C3, 3'd0, 32'h0000_00C3, 32'hC3};
        vecs[11] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 3'd2, 32'h00FF_FFFF, 32'hC3};

        #1;
        check("reset_out_async", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd0, rd); check("reset_data", rd, 32'h0);
        bus_read(3'd2, rd); check("reset_prescale", rd, 32'd12499999);
        bus_read(3'd6, rd); check("reset_status", rd, 32'h1);
        bus_read(3'd1, rd); check("reset_blink_en", rd, 32'h0);
        check("reset_out", 32'(out_port), 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr)
                bus_write(vecs[i].waddr, vecs[i].wdata);
            else
                @(negedge clk);
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            clk_step();
            check($sformatf("vec%0d_out", i), 32'(out_port), vecs[i].exp_out);
        end

        // One-edge output latency after a DATA write
        bus_write(3'd0, 32'h5A);
        check("latency_before", 32'(out_port), 32'hC3);
        clk_step();
        check("latency_after", 32'(out_port), 32'h5A);

        // Blink with PRESCALE=3: phase toggles every 4 clk, bit1 stays steady
        bus_write(3'd0, 32'h03);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'd3);
        for (int n = 1; n <= 16; n++) begin
            clk_step();
            bus_read(3'd6, rd);
            check($sformatf("blink_phase_n%0d", n), rd, ((n / 4) % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("blink_out_n%0d", n), 32'(out_port),
                  32'h2 | ((((n - 1) / 4) % 2 == 0) ? 32'h1 : 32'h0));
        end

        // PRESCALE rewritten on the edge where cnt hits its old terminal count
        bus_write(3'd2, 32'd3);
        clk_step(); clk_step(); clk_step();
        bus_write(3'd2, 32'd3);
        bus_read(3'd6, rd); check("collide_phase", rd, 32'h1);
        for (int n = 1; n <= 4; n++) begin
            clk_step();
            bus_read(3'd6, rd);
            check($sformatf("collide_n%0d", n), rd, (n < 4) ? 32'h1 : 32'h0);
        end

        // PRESCALE=0 toggles every clock
        bus_write(3'd2, 32'd0);
        for (int n = 1; n <= 4; n++) begin
            clk_step();
            bus_read(3'd6, rd);
            check($sformatf("presc0_n%0d", n), rd, (n % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Lowering PRESCALE below the running count restarts instead of wrapping
        bus_write(3'd2, 32'd100);
        for (int n = 0; n < 20; n++) clk_step();
        bus_write(3'd2, 32'd5);
        for (int n = 1; n <= 6; n++) begin
            clk_step();
            bus_read(3'd6, rd);
            check($sformatf("lower_n%0d", n), rd, (n < 6) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset mid-blink
        bus_write(3'd0, 32'hFF);
        bus_write(3'd2, 32'd3);
        for (int n = 0; n < 6; n++) clk_step();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_out", 32'(out_port), 32'h0);
        bus_read(3'd0, rd); check("areset_data", rd, 32'h0);
        bus_read(3'd1, rd); check("areset_blink_en", rd, 32'h0);
        bus_read(3'd2, rd); check("areset_prescale", rd, 32'd12499999);
        bus_read(3'd6, rd); check("areset_status", rd, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        clk_step();
        check("areset_out_held", 32'(out_port), 32'h0);

`ifdef LED_PIO_PWM_EN
        bus_read(3'd3, rd); check("duty_reset", rd, 32'hFF);
        bus_write(3'd0, 32'h01);
        bus_write(3'd3, 32'd64);
        highs = 0;
        for (int n = 0; n < 256; n++) begin
            clk_step();
            if (out_port[0]) highs++;
        end
        check("pwm_duty64", 32'(highs), 32'd64);
        bus_write(3'd3, 32'd0);
        clk_step();
        highs = 0;
        for (int n = 0; n < 256; n++) begin
            clk_step();
            if (out_port[0]) highs++;
        end
        check("pwm_duty0", 32'(highs), 32'd0);
`else
        bus_write(3'd3, 32'h40);
        bus_read(3'd3, rd); check("duty_absent", rd, 32'h0);
        highs = 0;
        check("duty_absent_count", 32'(highs), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
